// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//   Upstream bit source for the synchronous bit FIFO / sine modulator chain.
//   Takes parallel bytes over a valid/ready handshake (byte mode) or produces
//   a PRBS7 test pattern (PRBS mode), and writes one bit per cycle into the
//   FIFO, holding off whenever the FIFO is full so no bit is lost or repeated.
//
// Parameters
//   DATA_W     byte width, 2..16
//   MSB_FIRST  1: byte_in[DATA_W-1] leaves first, 0: byte_in[0] leaves first
//   PRBS_SEED  LFSR load value on PRBS entry (0 is replaced by 7'h01)
//
// Ports
//   CLK         in   system clock, rising edge
//   RESET       in   asynchronous active-low reset
//   enable      in   block may accept bytes / generate PRBS
//   mode        in   0 = byte mode, 1 = PRBS7 mode (sampled in IDLE)
//   byte_in     in   parallel data, qualified by byte_valid
//   byte_valid  in   upstream has a byte
//   byte_ready  out  byte_in is accepted this cycle
//   fifo_bFull  in   FIFO full flag (combinational from the FIFO)
//   fifo_wEN    out  FIFO write enable
//   fifo_dIn    out  FIFO write data bit
//   busy        out  state is not IDLE
//   bit_count   out  bits written since reset, wraps at 16 bits
// -----------------------------------------------------------------------------
module bit_serializer #(
   parameter int          DATA_W    = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter logic [6:0]  PRBS_SEED = 7'h7F
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              enable,
   input  logic              mode,
   input  logic [DATA_W-1:0] byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   input  logic              fifo_bFull,
   output logic              fifo_wEN,
   output logic              fifo_dIn,
   output logic              busy,
   output logic [15:0]       bit_count
);

   localparam int         CNT_W = $clog2(DATA_W + 1);
   // An all-zero LFSR would lock up, so a zero seed is substituted.
   localparam logic [6:0] SEED  = (PRBS_SEED == 7'h00) ? 7'h01 : PRBS_SEED;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_PRBS  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  sr_q, sr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [6:0]         lfsr_q, lfsr_d;
   logic [15:0]        bit_count_q, bit_count_d;

   logic               wr_s;
   logic               ready_s;
   logic               din_s;
   logic               head_s;
   logic [DATA_W-1:0]  sr_shift_s;

   // Head bit of the shift register and the register after one bit leaves.
   always_comb begin
      if (MSB_FIRST) begin
         head_s     = sr_q[DATA_W-1];
         sr_shift_s = {sr_q[DATA_W-2:0], 1'b0};
      end else begin
         head_s     = sr_q[0];
         sr_shift_s = {1'b0, sr_q[DATA_W-1:1]};
      end
   end

   // A write happens only when the FIFO has room; PRBS writes also need the
   // controls still pointing at PRBS, since leaving PRBS costs no write.
   assign wr_s = ((state_q == S_SHIFT) ||
                  ((state_q == S_PRBS) && enable && mode)) && !fifo_bFull;

   // Next-state, datapath updates and handshake/data outputs.
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      lfsr_d      = lfsr_q;
      bit_count_d = bit_count_q;
      ready_s     = 1'b0;
      din_s       = 1'b0;

      case (state_q)
         S_IDLE: begin
            ready_s = enable && !mode;
            if (byte_valid && ready_s) begin
               sr_d    = byte_in;
               cnt_d   = CNT_W'(DATA_W);
               state_d = S_SHIFT;
            end else if (enable && mode) begin
               lfsr_d  = SEED;
               state_d = S_PRBS;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_SHIFT: begin
            din_s = head_s;
            if (wr_s) begin
               bit_count_d = bit_count_q + 16'd1;
               if (cnt_q == CNT_W'(1)) begin
                  // Last bit leaving: take the next byte on the same edge
                  // so back-to-back bytes stream with no gap.
                  if (enable && !mode && byte_valid) begin
                     ready_s = 1'b1;
                     sr_d    = byte_in;
                     cnt_d   = CNT_W'(DATA_W);
                     state_d = S_SHIFT;
                  end else begin
                     sr_d    = sr_shift_s;
                     cnt_d   = {CNT_W{1'b0}};
                     state_d = S_IDLE;
                  end
               end else begin
                  sr_d  = sr_shift_s;
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end else begin
               state_d = S_SHIFT;
            end
         end

         S_PRBS: begin
            din_s = lfsr_q[6];
            if (!enable || !mode) begin
               state_d = S_IDLE;
            end else if (wr_s) begin
               // x^7 + x^6 + 1
               lfsr_d      = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
               bit_count_d = bit_count_q + 16'd1;
            end else begin
               state_d = S_PRBS;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= S_IDLE;
         sr_q        <= {DATA_W{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         lfsr_q      <= SEED;
         bit_count_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         lfsr_q      <= lfsr_d;
         bit_count_q <= bit_count_d;
      end
   end

   // byte_ready is gated by RESET so it drops the instant reset asserts,
   // even while enable is still high.
   assign byte_ready = ready_s && RESET;
   assign fifo_wEN   = wr_s;
   assign fifo_dIn   = din_s;
   assign busy       = (state_q != S_IDLE);
   assign bit_count  = bit_count_q;

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

   logic        CLK;
   logic        RESET;
   logic        enable;
   logic        mode;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        fifo_bFull;
   logic        fifo_wEN;
   logic        fifo_dIn;
   logic        busy;
   logic [15:0] bit_count;

   int checks   = 0;
   int failures = 0;

   bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .PRBS_SEED(7'h7F)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .enable     (enable),
      .mode       (mode),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .fifo_bFull (fifo_bFull),
      .fifo_wEN   (fifo_wEN),
      .fifo_dIn   (fifo_dIn),
      .busy       (busy),
      .bit_count  (bit_count)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic        en, md, bv;
      logic [7:0]  byt;
      logic        full;
      logic        rdy, wen, din, bsy;
      logic [15:0] bc;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic void add(input logic en, input logic md, input logic bv,
                               input logic [7:0] byt, input logic full,
                               input logic rdy, input logic wen, input logic din,
                               input logic bsy, input logic [15:0] bc);
      vec_t v;
      v.en = en; v.md = md; v.bv = bv; v.byt = byt; v.full = full;
      v.rdy = rdy; v.wen = wen; v.din = din; v.bsy = bsy; v.bc = bc;
      vecs.push_back(v);
   endfunction

   // n written bits in SHIFT; pat holds the expected bits, first one at pat[n-1].
   function automatic void add_run(input logic en, input logic bv, input logic [7:0] byt,
                                   input int n, input logic [7:0] pat,
                                   input logic rdy_last, input logic [15:0] bc0);
      for (int i = 0; i < n; i++)
         add(en, 1'b0, bv, byt, 1'b0, (i == n - 1) ? rdy_last : 1'b0,
             1'b1, pat[n-1-i], 1'b1, bc0 + 16'(i));
   endfunction

   logic        prbs_bits [0:253];
   logic [13:0] prbs_head;
   int          nw, cyc, per_err, ones;

   initial begin
      RESET = 1'b0; enable = 1'b0; mode = 1'b0; byte_in = 8'h00;
      byte_valid = 1'b0; fifo_bFull = 1'b0;

      // Byte 0xA5 MSB first, then idle.
      add(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
      add_run(1'b1, 1'b0, 8'h00, 8, 8'hA5, 1'b0, 16'd0);
      add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd8);
      // 0xFF then 0x00 streamed back to back.
      add(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd8);
      add_run(1'b1, 1'b1, 8'h00, 8, 8'hFF, 1'b1, 16'd8);
      add_run(1'b1, 1'b0, 8'h00, 8, 8'h00, 1'b0, 16'd16);
      add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd24);
      // 0xA5 with a 3-cycle full stall after the third bit.
      add(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd24);
      add_run(1'b1, 1'b0, 8'h00, 3, 8'b0000_0101, 1'b0, 16'd24);
      for (int i = 0; i < 3; i++)
         add(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd27);
      add_run(1'b1, 1'b0, 8'h00, 5, 8'b0000_0101, 1'b0, 16'd27);
      add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd32);
      // 0x3C, enable dropped after bit 4: byte still completes, no new accept.
      add(1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd32);
      add_run(1'b1, 1'b0, 8'h00, 4, 8'b0000_0011, 1'b0, 16'd32);
      add_run(1'b0, 1'b1, 8'h55, 4, 8'b0000_1100, 1'b0, 16'd36);
      add(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd40);
      // 0x81, last bit blocked by full with next byte waiting.
      add(1'b1, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd40);
      add_run(1'b1, 1'b0, 8'h00, 7, 8'b0100_0000, 1'b0, 16'd40);
      add(1'b1, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd47);
      add(1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd47);
      add_run(1'b1, 1'b0, 8'h00, 8, 8'h80, 1'b0, 16'd48);
      add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd56);

      // Reset state.
      #12;
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_wen", 16'(fifo_wEN), 16'd0);
      check("rst_din", 16'(fifo_dIn), 16'd0);
      check("rst_rdy", 16'(byte_ready), 16'd0);
      check("rst_bc", bit_count, 16'd0);
      @(negedge CLK);
      RESET = 1'b1;

      // Table-driven cycles.
      for (int r = 0; r < vecs.size(); r++) begin
         @(negedge CLK);
         enable = vecs[r].en; mode = vecs[r].md; byte_valid = vecs[r].bv;
         byte_in = vecs[r].byt; fifo_bFull = vecs[r].full;
         #1;
         check($sformatf("v%0d_rdy", r), 16'(byte_ready), 16'(vecs[r].rdy));
         check($sformatf("v%0d_wen", r), 16'(fifo_wEN), 16'(vecs[r].wen));
         check($sformatf("v%0d_din", r), 16'(fifo_dIn), 16'(vecs[r].din));
         check($sformatf("v%0d_busy", r), 16'(busy), 16'(vecs[r].bsy));
         check($sformatf("v%0d_bc", r), bit_count, vecs[r].bc);
      end

      // PRBS7 with random full stalls.
      @(negedge CLK);
      enable = 1'b1; mode = 1'b1; byte_valid = 1'b1; fifo_bFull = 1'b0;
      #1;
      check("prbs_entry_rdy", 16'(byte_ready), 16'd0);
      check("prbs_entry_busy", 16'(busy), 16'd0);
      nw = 0; cyc = 0;
      while (nw < 254 && cyc < 2000) begin
         @(negedge CLK);
         fifo_bFull = ($urandom_range(0, 3) == 0);
         #1;
         check("prbs_wen", 16'(fifo_wEN), 16'(!fifo_bFull));
         check("prbs_rdy", 16'(byte_ready), 16'd0);
         if (fifo_wEN === 1'b1 && nw < 254) begin
            prbs_bits[nw] = fifo_dIn;
            nw++;
         end
         cyc++;
      end
      check("prbs_timeout_bits", 16'(nw), 16'd254);
      prbs_head = 14'b11111110000001;
      for (int i = 0; i < 14; i++)
         check($sformatf("prbs_bit%0d", i), 16'(prbs_bits[i]), 16'(prbs_head[13-i]));
      per_err = 0; ones = 0;
      for (int i = 0; i < 127; i++) begin
         if (prbs_bits[i] !== prbs_bits[i+127]) per_err++;
         if (prbs_bits[i] === 1'b1) ones++;
      end
      check("prbs_period", 16'(per_err), 16'd0);
      check("prbs_ones", 16'(ones), 16'd64);
      @(negedge CLK);
      mode = 1'b0; fifo_bFull = 1'b0; byte_valid = 1'b0;
      #1;
      check("prbs_exit_wen", 16'(fifo_wEN), 16'd0);
      check("prbs_exit_bc", bit_count, 16'd310);
      @(negedge CLK);
      enable = 1'b0;
      #1;
      check("prbs_idle_busy", 16'(busy), 16'd0);
      check("prbs_idle_bc", bit_count, 16'd310);

      // Asynchronous reset in the middle of a byte.
      @(negedge CLK);
      enable = 1'b1; byte_valid = 1'b1; byte_in = 8'hA5;
      #1;
      check("ar_accept", 16'(byte_ready), 16'd1);
      @(negedge CLK);
      byte_valid = 1'b0;
      @(negedge CLK);
      #2;
      check("ar_pre_busy", 16'(busy), 16'd1);
      byte_valid = 1'b1;
      RESET = 1'b0;
      #1;
      check("ar_busy", 16'(busy), 16'd0);
      check("ar_wen", 16'(fifo_wEN), 16'd0);
      check("ar_rdy", 16'(byte_ready), 16'd0);
      check("ar_bc", bit_count, 16'd0);
      @(negedge CLK);
      enable = 1'b0; byte_valid = 1'b0;
      RESET = 1'b1;
      #1;
      check("ar_after_busy", 16'(busy), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
